vmem_wr_arb: RTL

Video-memory write buffer and SRAM access arbiter, directly downstream of the pattern generator and other video-memory writers. Accepts byte-lane write requests (active-low strobe, 16-bit word address, 8-bit data), buffers them in a FIFO, and flow-controls the writer with an almost-full flag. Drains the FIFO into the external 16-bit asynchronous SRAM, interleaved fairly with single-word read requests from the display fetcher.

---
 rtl/vmem_pkg.sv | 24 ++
 rtl/vmem_wr_fifo.sv | 48 ++++
 rtl/vmem_wr_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// Shared types for the video-memory write buffer and SRAM arbiter.
// State encoding, FIFO entry layout and SRAM word width.
package vmem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int SRAM_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    RD_ADDR,
    RD_CAPT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              up_n;
    logic              lo_n;
  } entry_t;

endpackage

// File: rtl/vmem_wr_fifo.sv
// Synchronous write-request FIFO; head entry is shown on dout.
// Push is ignored when full, pop is ignored when empty.
module vmem_wr_fifo
  import vmem_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  entry_t      din,
  output entry_t      dout,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vmem_wr_arb.sv
// Video-memory write buffer + SRAM arbiter, fair read/write interleave.
// Define VMEM_WR_ARB_OVF_EN to build the sticky overflow flag.
module vmem_wr_arb
  import vmem_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wr_n,
  input  logic [15:0] i_addr,
  input  logic        i_vmem_up_n,
  input  logic        i_vmem_lo_n,
  input  logic [7:0]  i_vmem_data,
  output logic        o_afull,
  output logic        o_ovf,
  input  logic        i_rd_req,
  input  logic [15:0] i_rd_addr,
  output logic        o_rd_ack,
  output logic        o_rd_valid,
  output logic [15:0] o_rd_data,
  output logic [15:0] o_sram_addr,
  output logic [15:0] o_sram_dq,
  output logic        o_sram_dq_oe,
  input  logic [15:0] i_sram_dq,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_nx;
  entry_t            din;
  entry_t            head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic              wr_turn;
  logic              turn_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [SRAM_W-1:0] dq_nx;
  logic [SRAM_W-1:0] rdata_nx;
  logic              dq_oe_nx;
  logic              we_nx;
  logic              oe_nx;
  logic              ub_nx;
  logic              lb_nx;
  logic              ack_nx;
  logic              vld_nx;

  // A request with both lanes disabled carries nothing to write.
  assign push = !i_wr_n && !(i_vmem_up_n && i_vmem_lo_n);
  assign din  = {i_addr, i_vmem_data, i_vmem_up_n, i_vmem_lo_n};

  vmem_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign o_afull = (level >= LW'(AFULL_LVL));

`ifdef VMEM_WR_ARB_OVF_EN
  logic ovf;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      ovf <= 1'b0;
    else if (push && full)
      ovf <= 1'b1;
  end

  assign o_ovf = ovf;
`else
  logic unused_full;

  assign unused_full = full;
  assign o_ovf       = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      wr_turn      <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_we_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_rd_ack     <= 1'b0;
      o_rd_valid   <= 1'b0;
      o_rd_data    <= '0;
    end else begin
      state        <= state_nx;
      wr_turn      <= turn_nx;
      o_sram_addr  <= addr_nx;
      o_sram_dq    <= dq_nx;
      o_sram_dq_oe <= dq_oe_nx;
      o_sram_we_n  <= we_nx;
      o_sram_oe_n  <= oe_nx;
      o_sram_ub_n  <= ub_nx;
      o_sram_lb_n  <= lb_nx;
      o_rd_ack     <= ack_nx;
      o_rd_valid   <= vld_nx;
      o_rd_data    <= rdata_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && (wr_turn || !i_rd_req)) begin
          state_nx = WR_SETUP;
          pop      = 1'b1;
        end else if (i_rd_req) begin
          state_nx = RD_ADDR;
        end
      end
      WR_SETUP: state_nx = WR_PULSE;
      WR_PULSE: state_nx = IDLE;
      RD_ADDR:  state_nx = RD_CAPT;
      RD_CAPT:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Next values of the registered SRAM pins, keyed on the current state.
  always_comb begin
    addr_nx  = o_sram_addr;
    dq_nx    = o_sram_dq;
    dq_oe_nx = o_sram_dq_oe;
    we_nx    = 1'b1;
    oe_nx    = 1'b1;
    ub_nx    = o_sram_ub_n;
    lb_nx    = o_sram_lb_n;
    ack_nx   = 1'b0;
    vld_nx   = 1'b0;
    rdata_nx = o_rd_data;
    turn_nx  = wr_turn;
    unique case (state)
      IDLE: begin
        if (pop) begin
          addr_nx  = head.addr;
          dq_nx    = {head.data, head.data};
          dq_oe_nx = 1'b1;
          ub_nx    = head.up_n;
          lb_nx    = head.lo_n;
        end else if (state_nx == RD_ADDR) begin
          addr_nx  = i_rd_addr;
          dq_oe_nx = 1'b0;
          oe_nx    = 1'b0;
          ub_nx    = 1'b0;
          lb_nx    = 1'b0;
          ack_nx   = 1'b1;
        end
      end
      WR_SETUP: we_nx = 1'b0;
      WR_PULSE: begin
        dq_oe_nx = 1'b0;
        ub_nx    = 1'b1;
        lb_nx    = 1'b1;
        turn_nx  = 1'b0;
      end
      RD_ADDR: oe_nx = 1'b0;
      RD_CAPT: begin
        rdata_nx = i_sram_dq;
        vld_nx   = 1'b1;
        ub_nx    = 1'b1;
        lb_nx    = 1'b1;
        turn_nx  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
